// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: op classes, FSM states,
// stage-control bundles and the writes-register decode.
package pipe_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_STORE  = 4'd2;
  localparam logic [3:0] OP_ALU    = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_JUMP   = 4'd5;

  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDSTALL,
    ST_MWAIT,
    ST_ERR
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if2id_en;
    logic id2ex_en;
    logic ex2mem_en;
    logic mem2wb_en;
    logic if2id_flush;
    logic id2ex_flush;
    logic ex2mem_flush;
    logic mem2wb_flush;
    logic pc_sel_jump;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if2id_en: 1'b1, id2ex_en: 1'b1, ex2mem_en: 1'b1, mem2wb_en: 1'b1,
    if2id_flush: 1'b0, id2ex_flush: 1'b0, ex2mem_flush: 1'b0, mem2wb_flush: 1'b0,
    pc_sel_jump: 1'b0
  };

  // Everything upstream of MEM holds; MEM->WB keeps moving but carries a bubble.
  localparam ctrl_t CTRL_MWAIT = '{
    pc_en: 1'b0, if2id_en: 1'b0, id2ex_en: 1'b0, ex2mem_en: 1'b0, mem2wb_en: 1'b1,
    if2id_flush: 1'b0, id2ex_flush: 1'b0, ex2mem_flush: 1'b0, mem2wb_flush: 1'b1,
    pc_sel_jump: 1'b0
  };

  localparam ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if2id_en: 1'b1, id2ex_en: 1'b1, ex2mem_en: 1'b1, mem2wb_en: 1'b1,
    if2id_flush: 1'b1, id2ex_flush: 1'b1, ex2mem_flush: 1'b1, mem2wb_flush: 1'b0,
    pc_sel_jump: 1'b1
  };

  localparam ctrl_t CTRL_LDUSE = '{
    pc_en: 1'b0, if2id_en: 1'b0, id2ex_en: 1'b1, ex2mem_en: 1'b1, mem2wb_en: 1'b1,
    if2id_flush: 1'b0, id2ex_flush: 1'b1, ex2mem_flush: 1'b0, mem2wb_flush: 1'b0,
    pc_sel_jump: 1'b0
  };

  localparam ctrl_t CTRL_FROZEN = '{
    pc_en: 1'b0, if2id_en: 1'b0, id2ex_en: 1'b0, ex2mem_en: 1'b0, mem2wb_en: 1'b0,
    if2id_flush: 1'b0, id2ex_flush: 1'b0, ex2mem_flush: 1'b0, mem2wb_flush: 1'b0,
    pc_sel_jump: 1'b0
  };

  function automatic logic writes_reg(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_ALU);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one EX source register: MEM result first,
// then WB result, otherwise the register-file value.
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic [3:0] mem_op_type,
  input  logic [4:0] mem_write_reg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_write_reg,
  output logic [1:0] fwd
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    // Load data is not available in MEM yet; that case is covered by the load-use stall.
    mem_hit = writes_reg(mem_op_type) && (mem_op_type != OP_LOAD) &&
              (mem_write_reg != '0) && (mem_write_reg == ex_src);
    wb_hit  = wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == ex_src);
    fwd     = 2'b00;
    if (mem_hit) begin
      fwd = 2'b10;
    end else if (wb_hit) begin
      fwd = 2'b01;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall, branch flush,
// memory-wait hold with timeout. Optional stall counter under HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [3:0]  ex_op_type,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_write_reg,
  input  logic [3:0]  mem_op_type,
  input  logic [4:0]  mem_write_reg,
  input  logic        mem_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  output logic        pc_en,
  output logic        if2id_en,
  output logic        id2ex_en,
  output logic        ex2mem_en,
  output logic        mem2wb_en,
  output logic        if2id_flush,
  output logic        id2ex_flush,
  output logic        ex2mem_flush,
  output logic        mem2wb_flush,
  output logic        pc_sel_jump,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_timeout
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  hz_state_e  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  ctrl_t      ctrl;
  logic       mem_wait;
  logic       load_use;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  pipe_fwd_unit u_fwd_a (
    .ex_src        (ex_rs),
    .mem_op_type   (mem_op_type),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .fwd           (fwd_a_raw)
  );

  pipe_fwd_unit u_fwd_b (
    .ex_src        (ex_rt),
    .mem_op_type   (mem_op_type),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .fwd           (fwd_b_raw)
  );

  always_comb begin
    mem_wait = mem_req && !mem_ack;
    load_use = (ex_op_type == OP_LOAD) && (ex_write_reg != '0) &&
               ((id_use_rs && (id_rs == ex_write_reg)) ||
                (id_use_rt && (id_rt == ex_write_reg)));
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctrl          = CTRL_RUN;
    if (reset) begin
      state_d       = ST_RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b0;
    end else if (state_q == ST_ERR) begin
      ctrl = CTRL_FROZEN;
    end else if ((state_q == ST_MWAIT) && !mem_ack) begin
      ctrl       = CTRL_MWAIT;
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_d == WAIT_LIMIT) begin
        state_d       = ST_ERR;
        mem_timeout_d = 1'b1;
      end
    end else if (mem_wait) begin
      ctrl       = CTRL_MWAIT;
      state_d    = ST_MWAIT;
      wait_cnt_d = '0;
    end else if (mem_branch_taken) begin
      // The ack cycle of MWAIT lands here too: MEM was held, so a pending branch is still visible.
      ctrl    = CTRL_BRANCH;
      state_d = ST_RUN;
    end else if (load_use && (state_q != ST_LDSTALL)) begin
      ctrl    = CTRL_LDUSE;
      state_d = ST_LDSTALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  assign pc_en        = ctrl.pc_en;
  assign if2id_en     = ctrl.if2id_en;
  assign id2ex_en     = ctrl.id2ex_en;
  assign ex2mem_en    = ctrl.ex2mem_en;
  assign mem2wb_en    = ctrl.mem2wb_en;
  assign if2id_flush  = ctrl.if2id_flush;
  assign id2ex_flush  = ctrl.id2ex_flush;
  assign ex2mem_flush = ctrl.ex2mem_flush;
  assign mem2wb_flush = ctrl.mem2wb_flush;
  assign pc_sel_jump  = ctrl.pc_sel_jump;
  assign fwd_a        = reset ? 2'b00 : fwd_a_raw;
  assign fwd_b        = reset ? 2'b00 : fwd_b_raw;
  assign mem_timeout  = mem_timeout_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (reset) begin
      stall_cycles_d = '0;
    end else if (!ctrl.pc_en && (state_q != ST_ERR)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
